// File: rtl/bcd_updown_counter_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and load clamp helper
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// bcd_updown_counter_if: counter bus; master drives en/up/load/load_val, slave returns q/tc/zero/load_err
interface bcd_updown_counter_if #(parameter int N_DIGITS = 4);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*N_DIGITS-1:0] load_val;
  logic [4*N_DIGITS-1:0] q;
  logic                  tc;
  logic                  zero;
  logic                  load_err;
  modport master (output en, up, load, load_val, input q, tc, zero, load_err);
  modport slave (input en, up, load, load_val, output q, tc, zero, load_err);
endinterface

// File: rtl/bcd_updown_counter_digit.sv
// bcd_digit: one BCD digit cell; ports clk, reset, step, up, load, load_digit in; q, at_max, at_min out
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);
  bcd_digit_t r_q;
  bcd_digit_t w_next;
  always_comb begin
    w_next = (r_q > BCD_MAX) ? BCD_MIN :
             up ? ((r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1) :
                  ((r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) r_q <= BCD_MIN;
    else if (load) r_q <= bcd_clamp(load_digit);
    else if (step) r_q <= w_next;
  end
  assign q      = r_q;
  assign at_max = (r_q == BCD_MAX);
  assign at_min = (r_q == BCD_MIN);
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit BCD up/down counter with load, wrap/saturate; ports clk, reset, bus (slave)
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter bit WRAP     = 1'b1
) (
  input logic clk,
  input logic reset,
  bcd_updown_counter_if.slave bus
);
  logic [N_DIGITS-1:0]   w_at_max, w_at_min, w_step;
  logic [N_DIGITS:0]     w_all_max, w_all_min;
  logic [4*N_DIGITS-1:0] w_q;
  logic                  w_bad, w_en, r_load_err;
  always_comb begin
    w_all_max[0] = 1'b1;
    w_all_min[0] = 1'b1;
    w_bad        = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_all_max[i+1] = w_all_max[i] & w_at_max[i];
      w_all_min[i+1] = w_all_min[i] & w_at_min[i];
      w_bad          = w_bad | (bus.load_val[4*i +: 4] > BCD_MAX);
    end
  end
  assign bus.tc = bus.en & (bus.up ? w_all_max[N_DIGITS] : w_all_min[N_DIGITS]);
  assign w_en   = bus.en & (WRAP | ~bus.tc);
  genvar k;
  generate
    for (k = 0; k < N_DIGITS; k++) begin : g_digit
      assign w_step[k] = w_en & (bus.up ? w_all_max[k] : w_all_min[k]);
      bcd_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .step       (w_step[k]),
        .up         (bus.up),
        .load       (bus.load),
        .load_digit (bus.load_val[4*k +: 4]),
        .q          (w_q[4*k +: 4]),
        .at_max     (w_at_max[k]),
        .at_min     (w_at_min[k])
      );
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset) r_load_err <= 1'b0;
    else r_load_err <= bus.load & w_bad;
  end
  assign bus.q        = w_q;
  assign bus.zero     = w_all_min[N_DIGITS];
  assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: table-driven scoreboard bench for wrap and saturate counter instances
module tb_bcd_updown_counter;
  logic        clk = 1'b0;
  logic        rst, en, up, ld;
  logic [15:0] lv;
  int          n_checks = 0;
  int          n_fail = 0;
  typedef struct {
    logic        rst, en, up, ld;
    logic [15:0] lv;
    logic        tc1, tc0;
    logic [15:0] q1, q0;
    logic        err;
  } vec_t;
  typedef struct {
    logic [15:0] q1, q0;
    logic        err;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  bcd_updown_counter_if #(.N_DIGITS(4)) ifa ();
  bcd_updown_counter_if #(.N_DIGITS(4)) ifb ();
  assign ifa.en = en;
  assign ifa.up = up;
  assign ifa.load = ld;
  assign ifa.load_val = lv;
  assign ifb.en = en;
  assign ifb.up = up;
  assign ifb.load = ld;
  assign ifb.load_val = lv;
  bcd_updown_counter #(.N_DIGITS(4), .WRAP(1'b1)) dut_wrap (.clk(clk), .reset(rst), .bus(ifa.slave));
  bcd_updown_counter #(.N_DIGITS(4), .WRAP(1'b0)) dut_sat (.clk(clk), .reset(rst), .bus(ifb.slave));
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void add(input logic r, e, u, l, input logic [15:0] v,
                              input logic t1, t0, input logic [15:0] q1, q0, input logic er);
    vec_t x;
    x = '{r, e, u, l, v, t1, t0, q1, q0, er};
    tbl.push_back(x);
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    exp_t e;
    rst = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; lv = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_q1", ifa.q, 16'h0000);
    chk("reset_q0", ifb.q, 16'h0000);
    chk("reset_zero", {15'b0, ifa.zero}, 16'h1);
    chk("reset_err", {15'b0, ifa.load_err}, 16'h0);
    chk("reset_tc_en0", {15'b0, ifa.tc}, 16'h0);
    en = 1'b1;
    #1;
    chk("reset_tc_down", {15'b0, ifa.tc}, 16'h1);
    for (int i = 1; i <= 10; i++)
      add(0, 1, 1, 0, 0, 0, 0, i < 10 ? 16'(i) : 16'h0010, i < 10 ? 16'(i) : 16'h0010, 0);
    add(0, 0, 1, 1, 16'h0999, 0, 0, 16'h0999, 16'h0999, 0);
    add(0, 1, 1, 0, 0,        0, 0, 16'h1000, 16'h1000, 0);
    add(0, 0, 1, 1, 16'h9999, 0, 0, 16'h9999, 16'h9999, 0);
    add(0, 1, 1, 0, 0,        1, 1, 16'h0000, 16'h9999, 0);
    add(0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    add(0, 1, 0, 0, 0,        1, 1, 16'h9999, 16'h0000, 0);
    add(0, 0, 0, 1, 16'h0002, 0, 0, 16'h0002, 16'h0002, 0);
    add(0, 1, 0, 0, 0,        0, 0, 16'h0001, 16'h0001, 0);
    add(0, 1, 0, 0, 0,        0, 0, 16'h0000, 16'h0000, 0);
    add(0, 1, 0, 0, 0,        1, 1, 16'h9999, 16'h0000, 0);
    add(0, 1, 0, 0, 0,        0, 1, 16'h9998, 16'h0000, 0);
    add(0, 1, 0, 0, 0,        0, 1, 16'h9997, 16'h0000, 0);
    add(0, 0, 1, 1, 16'h9998, 0, 0, 16'h9998, 16'h9998, 0);
    add(0, 1, 1, 0, 0,        0, 0, 16'h9999, 16'h9999, 0);
    add(0, 1, 1, 0, 0,        1, 1, 16'h0000, 16'h9999, 0);
    add(0, 1, 1, 0, 0,        0, 1, 16'h0001, 16'h9999, 0);
    add(0, 1, 1, 1, 16'h3A7F, 0, 1, 16'h3979, 16'h3979, 1);
    add(0, 0, 1, 0, 0,        0, 0, 16'h3979, 16'h3979, 0);
    add(0, 0, 1, 1, 16'h0500, 0, 0, 16'h0500, 16'h0500, 0);
    add(0, 1, 1, 0, 0,        0, 0, 16'h0501, 16'h0501, 0);
    add(1, 1, 1, 1, 16'h9F9F, 0, 0, 16'h0000, 16'h0000, 0);
    add(0, 0, 1, 1, 16'h0500, 0, 0, 16'h0500, 16'h0500, 0);
    add(0, 1, 0, 0, 0,        0, 0, 16'h0499, 16'h0499, 0);
    add(0, 1, 1, 0, 0,        0, 0, 16'h0500, 16'h0500, 0);
    add(0, 1, 0, 0, 0,        0, 0, 16'h0499, 16'h0499, 0);
    add(0, 1, 1, 0, 0,        0, 0, 16'h0500, 16'h0500, 0);
    add(1, 1, 0, 0, 0,        0, 0, 16'h0000, 16'h0000, 0);
    add(0, 0, 0, 1, 16'hAAAA, 0, 0, 16'h9999, 16'h9999, 1);
    add(1, 0, 0, 0, 0,        0, 0, 16'h0000, 16'h0000, 0);
    add(0, 0, 0, 0, 0,        0, 0, 16'h0000, 16'h0000, 0);
    add(0, 1, 0, 0, 0,        1, 1, 16'h9999, 16'h0000, 0);
    rst = 1'b0;
    foreach (tbl[n]) begin
      rst = tbl[n].rst; en = tbl[n].en; up = tbl[n].up; ld = tbl[n].ld; lv = tbl[n].lv;
      #2;
      chk($sformatf("tc_wrap[%0d]", n), {15'b0, ifa.tc}, {15'b0, tbl[n].tc1});
      chk($sformatf("tc_sat[%0d]", n), {15'b0, ifb.tc}, {15'b0, tbl[n].tc0});
      sb.push_back('{tbl[n].q1, tbl[n].q0, tbl[n].err});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", n);
      end else begin
        e = sb.pop_front();
        chk($sformatf("q_wrap[%0d]", n), ifa.q, e.q1);
        chk($sformatf("q_sat[%0d]", n), ifb.q, e.q0);
        chk($sformatf("zero_wrap[%0d]", n), {15'b0, ifa.zero}, {15'b0, e.q1 == 16'h0});
        chk($sformatf("zero_sat[%0d]", n), {15'b0, ifb.zero}, {15'b0, e.q0 == 16'h0});
        chk($sformatf("err_wrap[%0d]", n), {15'b0, ifa.load_err}, {15'b0, e.err});
        chk($sformatf("err_sat[%0d]", n), {15'b0, ifb.load_err}, {15'b0, e.err});
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
